// File: rtl/inst_fetch_unit.sv
// IF-stage fetch unit: owns the PC, issues one instruction-bus read at a time and
// hands instructions to IF/ID, honouring delay-slot branches, exception flushes and misaligned fetches.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int          EXC_ADEL_BIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [5:0]  if_exception_type,
  output logic        inst_stall
);

  localparam logic [5:0] ADEL_MASK = 6'b000001 << EXC_ADEL_BIT;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ERR
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [31:0] r_pc;
  logic        r_pendValid;
  logic [31:0] r_pendTarget;
  logic        r_discard;
  logic [31:0] r_holdInstr;
  // A flushed request that was never accepted keeps driving its old address until addr_ok.
  logic        r_flushReq;
  logic [31:0] r_flushAddr;

  logic        w_pcMisaligned;
  logic        w_accept;
  logic        w_dataFromBus;
  logic        w_busData;
  logic        w_present;
  logic        w_deliver;
  logic        w_branchTake;
  logic        w_staleOutstanding;
  logic        w_staleUnaccepted;
  logic [31:0] w_advancePc;

  assign w_pcMisaligned = (r_pc[1:0] != 2'b00);
  assign w_accept       = inst_req && inst_addr_ok;
  assign w_dataFromBus  = ((r_state == ST_REQ) && w_accept && inst_data_ok) ||
                          ((r_state == ST_WAIT) && inst_data_ok);
  assign w_busData      = w_dataFromBus && !r_discard;
  assign w_present      = !rst && !exception &&
                          ((r_state == ST_HOLD) || (r_state == ST_ERR) || w_busData);
  assign w_deliver      = w_present && !stall;
  assign w_branchTake   = !rst && !exception && branch_flag && !stall;

  assign w_staleOutstanding = ((r_state == ST_WAIT) && !inst_data_ok) ||
                              ((r_state == ST_REQ) && w_accept && !inst_data_ok);
  assign w_staleUnaccepted  = (r_state == ST_REQ) && inst_req && !inst_addr_ok;

  // A branch seen in the same cycle as a delivery means the delivered word was the delay slot.
  assign w_advancePc = w_branchTake ? branch_target :
                       r_pendValid  ? r_pendTarget  :
                       r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (exception) begin
      unique case (r_state)
        ST_REQ: begin
          if (w_accept && !inst_data_ok) begin
            w_nextState = ST_WAIT;
          end else begin
            w_nextState = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            w_nextState = ST_REQ;
          end
        end
        default: w_nextState = ST_REQ;
      endcase
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (!r_flushReq && w_pcMisaligned) begin
            w_nextState = ST_ERR;
          end else if (w_accept) begin
            if (!inst_data_ok) begin
              w_nextState = ST_WAIT;
            end else if (!r_discard && stall) begin
              w_nextState = ST_HOLD;
            end else begin
              w_nextState = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            if (!r_discard && stall) begin
              w_nextState = ST_HOLD;
            end else begin
              w_nextState = ST_REQ;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_nextState = ST_REQ;
          end
        end
        ST_ERR: begin
          if (!stall) begin
            w_nextState = ST_REQ;
          end
        end
        default: w_nextState = ST_REQ;
      endcase
    end
  end

  always_comb begin
    inst_wr           = 1'b0;
    inst_size         = 2'b10;
    inst_req          = !rst && (r_state == ST_REQ) && (r_flushReq || !w_pcMisaligned);
    inst_addr         = r_flushReq ? r_flushAddr : r_pc;
    inst_stall        = !w_present;
    if_pc             = 32'd0;
    if_instr          = 32'd0;
    if_exception_type = 6'd0;
    if (w_present) begin
      if_pc = r_pc;
      unique case (r_state)
        ST_HOLD: if_instr = r_holdInstr;
        ST_ERR:  if_exception_type = ADEL_MASK;
        default: if_instr = inst_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pendValid  <= 1'b0;
      r_pendTarget <= 32'd0;
      r_discard    <= 1'b0;
      r_holdInstr  <= 32'd0;
      r_flushReq   <= 1'b0;
      r_flushAddr  <= 32'd0;
    end else if (exception) begin
      r_pc        <= exception_pc;
      r_pendValid <= 1'b0;
      r_discard   <= w_staleOutstanding || w_staleUnaccepted;
      r_flushReq  <= w_staleUnaccepted;
      if (w_staleUnaccepted) begin
        r_flushAddr <= inst_addr;
      end
    end else begin
      if (w_deliver) begin
        r_pc        <= w_advancePc;
        r_pendValid <= 1'b0;
      end else if (w_branchTake) begin
        r_pendValid  <= 1'b1;
        r_pendTarget <= branch_target;
      end
      if (w_accept) begin
        r_flushReq <= 1'b0;
      end
      if (w_dataFromBus) begin
        r_discard <= 1'b0;
      end
      if (w_busData && stall) begin
        r_holdInstr <= inst_rdata;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: a random-latency SRAM bus model feeds
// the DUT while an architectural instruction-stream model predicts every delivered word.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        exception = 1'b0;
  logic [31:0] exception_pc = 32'd0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [5:0]  if_exception_type;
  logic        inst_stall;

  inst_fetch_unit #(
    .RESET_PC    (RESET_PC),
    .EXC_ADEL_BIT(0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .exception        (exception),
    .exception_pc     (exception_pc),
    .branch_flag      (branch_flag),
    .branch_target    (branch_target),
    .inst_req         (inst_req),
    .inst_wr          (inst_wr),
    .inst_size        (inst_size),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .if_exception_type(if_exception_type),
    .inst_stall       (inst_stall)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          deliveries = 0;
  logic [31:0] expQ[$];
  bit          deliveredFlag = 0;
  bit          slotOutstanding = 0;

  bit          busBusy = 0;
  int          busDelay = 0;
  int          busWait = 0;
  logic [31:0] busAddr = 32'd0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // The stream model always holds the next few architectural PCs in delivery order.
  function automatic void refill();
    while (expQ.size() < 4) begin
      expQ.push_back(expQ[expQ.size() - 1] + 32'd4);
    end
  endfunction

  function automatic void resetModel();
    expQ.delete();
    expQ.push_back(RESET_PC);
    refill();
    slotOutstanding = 0;
  endfunction

  function automatic logic [31:0] pickTarget();
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0:       t = 32'hBFC0_0102;
      1:       t = 32'hFFFF_FFF8;
      default: t = 32'hBFC0_0000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    endcase
    return t;
  endfunction

  function automatic logic [31:0] pickExcPc();
    logic [31:0] e;
    case ($urandom_range(0, 2))
      0:       e = 32'hBFC0_0380;
      1:       e = 32'h8000_0180;
      default: e = 32'hFFFF_FFF8;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // SRAM-like slave: random addr_ok wait, data 0..3 cycles after acceptance.
  always @(posedge clk) begin
    #2;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (busBusy) begin
      if (busDelay == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = memWord(busAddr);
        busBusy      = 0;
      end else begin
        busDelay--;
      end
    end else if (inst_req) begin
      if (busWait == 0) begin
        int d;
        inst_addr_ok = 1'b1;
        busAddr      = inst_addr;
        busWait      = $urandom_range(0, 2);
        d            = $urandom_range(0, 3);
        if (d == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = memWord(busAddr);
        end else begin
          busBusy  = 1;
          busDelay = d - 1;
        end
      end else begin
        busWait--;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_inert",
                  {inst_req, inst_stall, if_pc, if_instr, if_exception_type},
                  {1'b0, 1'b1, 32'd0, 32'd0, 6'd0});
    end else if (exception) begin
      checkOutput("exception_inert", {71'd0, inst_stall}, {71'd0, 1'b1});
    end else if (!inst_stall && !stall) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL deliver: got pc %h but no delivery expected", if_pc);
      end else begin
        logic [31:0] pc;
        logic        bad;
        pc  = expQ.pop_front();
        bad = (pc[1:0] != 2'b00);
        refill();
        checkOutput("deliver",
                    {1'b0, inst_stall, if_pc, if_instr, if_exception_type},
                    {1'b0, 1'b0, pc, bad ? 32'd0 : memWord(pc), bad ? 6'h01 : 6'h00});
      end
      deliveries++;
      deliveredFlag = 1;
    end
    if (!rst && inst_req && inst_addr_ok) begin
      checkOutput("bus_request", {67'd0, inst_addr[1:0], inst_wr, inst_size},
                  {67'd0, 2'b00, 1'b0, 2'b10});
    end
  end

  task automatic applyStimulus(input int cyc);
    int r;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    exception     = 1'b0;
    branch_flag   = 1'b0;
    branch_target = $urandom;
    r = $urandom_range(0, 999);
    if (cyc < 2 || r < 4) begin
      rst   = 1'b1;
      stall = 1'($urandom_range(0, 1));
      resetModel();
    end else if (r < 20) begin
      exception    = 1'b1;
      exception_pc = pickExcPc();
      stall        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        branch_flag   = 1'b1;
        branch_target = pickTarget();
      end
      expQ.delete();
      expQ.push_back(exception_pc);
      refill();
      slotOutstanding = 0;
    end else begin
      stall = ($urandom_range(0, 9) < 3);
      if (deliveredFlag && slotOutstanding) begin
        slotOutstanding = 0;
      end else if (deliveredFlag && $urandom_range(0, 2) == 0) begin
        logic [31:0] slotPc;
        branch_flag   = 1'b1;
        stall         = 1'b0;
        branch_target = pickTarget();
        slotPc        = expQ[0];
        expQ.delete();
        expQ.push_back(slotPc);
        expQ.push_back(branch_target);
        refill();
        slotOutstanding = 1;
      end else if ($urandom_range(0, 29) == 0) begin
        branch_flag = 1'b1;
        stall       = 1'b1;
      end
    end
    deliveredFlag = 0;
  endtask

  initial begin
    resetModel();
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(c);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exception = 1'b0;
    branch_flag = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    checkOutput("delivery_count", {71'd0, (deliveries >= 200)}, {71'd0, 1'b1});
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
